// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// legal oversampling ratios and the default frame width.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_VALID
    } rx_state_t;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned BIT_CNT_W      = 4;
    localparam int unsigned PRESCALE_8     = 8;
    localparam int unsigned PRESCALE_16    = 16;
    localparam int unsigned PRESCALE_32    = 32;

    // States in which the line is being sampled and the edge counter runs.
    function automatic logic is_active(input rx_state_t s);
        return s inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};
    endfunction

endpackage

// File: rtl/edge_bit_counter.sv
// Oversample edge counter and data bit counter, sequenced by the RX FSM.
module edge_bit_counter
    import uart_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  edge_en,
    input  logic                  bit_clr,
    input  logic                  bit_inc,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  edge_last_c,
    output logic [PRESCALE_W-1:0] edge_nxt_c,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt
);

    always_comb begin
        edge_last_c = (edge_cnt == (prescale - PRESCALE_W'(1)));
        edge_nxt_c  = (edge_en && !edge_last_c) ? edge_cnt + PRESCALE_W'(1) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            edge_cnt <= edge_nxt_c;
            if (bit_clr) begin
                bit_cnt <= '0;
            end else if (bit_inc) begin
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive controller: start detection, per-frame sequencing of the
// sampler/deserializer/checkers, and the data_valid / frame_err report.
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    input  logic                  strt_glitch,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic                  dat_samp_en,
    output logic                  deser_en,
    output logic                  strt_chk_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  data_valid,
    output logic                  frame_err
);

    rx_state_t             state;
    rx_state_t             state_nxt;
    logic                  err_flag;
    logic                  err_nxt;
    logic                  par_en_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic                  start_go;
    logic                  frame_err_nxt;
    logic                  bit_clr;
    logic                  bit_inc;
    logic                  edge_last;
    logic                  chk_nxt;
    logic [PRESCALE_W-1:0] edge_nxt;

    edge_bit_counter #(
        .PRESCALE_W (PRESCALE_W)
    ) u_cnt (
        .clk         (CLK),
        .rst         (RST),
        .edge_en     (is_active(state)),
        .bit_clr     (bit_clr),
        .bit_inc     (bit_inc),
        .prescale    (prescale_q),
        .edge_last_c (edge_last),
        .edge_nxt_c  (edge_nxt),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt)
    );

    // Next-state and counter control.
    always_comb begin
        state_nxt     = state;
        err_nxt       = err_flag;
        frame_err_nxt = 1'b0;
        bit_clr       = 1'b0;
        bit_inc       = 1'b0;
        start_go      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!RX_IN) begin
                    state_nxt = ST_START;
                    start_go  = 1'b1;
                end
            end
            ST_START: begin
                if (edge_last) begin
                    if (strt_glitch) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_DATA;
                        bit_clr   = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (edge_last) begin
                    bit_inc = 1'b1;
                    if (bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                        state_nxt = par_en_q ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (edge_last) begin
                    state_nxt = ST_STOP;
                    if (par_err) begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (edge_last) begin
                    if (stp_err || err_flag) begin
                        state_nxt     = ST_IDLE;
                        frame_err_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_VALID;
                    end
                end
            end
            ST_VALID: begin
                if (!RX_IN) begin
                    state_nxt = ST_START;
                    start_go  = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (start_go) begin
            err_nxt = 1'b0;
        end
        chk_nxt = (edge_nxt == (prescale_q - PRESCALE_W'(2)));
    end

    // Outputs are registered from the next state/edge so they line up with
    // the state and counter they describe.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_IDLE;
            err_flag    <= 1'b0;
            par_en_q    <= 1'b0;
            prescale_q  <= PRESCALE_W'(PRESCALE_8);
            dat_samp_en <= 1'b0;
            strt_chk_en <= 1'b0;
            deser_en    <= 1'b0;
            par_chk_en  <= 1'b0;
            stp_chk_en  <= 1'b0;
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            err_flag <= err_nxt;
            if (start_go) begin
                par_en_q   <= PAR_EN;
                prescale_q <= PRESCALE;
            end
            dat_samp_en <= is_active(state_nxt);
            strt_chk_en <= (state_nxt == ST_START)  && chk_nxt;
            deser_en    <= (state_nxt == ST_DATA)   && chk_nxt;
            par_chk_en  <= (state_nxt == ST_PARITY) && chk_nxt;
            stp_chk_en  <= (state_nxt == ST_STOP)   && chk_nxt;
            data_valid  <= (state_nxt == ST_VALID);
            frame_err   <= frame_err_nxt;
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: frame table, hand-written corner
// sequences and random frames against a per-cycle frame-timing model.
module tb_uart_rx_fsm;

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic [5:0] PRESCALE;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic       dat_samp_en;
    logic       deser_en;
    logic       strt_chk_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       data_valid;
    logic       frame_err;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    uart_rx_fsm dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .PAR_EN      (PAR_EN),
        .PRESCALE    (PRESCALE),
        .strt_glitch (strt_glitch),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .dat_samp_en (dat_samp_en),
        .deser_en    (deser_en),
        .strt_chk_en (strt_chk_en),
        .par_chk_en  (par_chk_en),
        .stp_chk_en  (stp_chk_en),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .data_valid  (data_valid),
        .frame_err   (frame_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int         p;
        bit         pe;
        logic [7:0] d;
        bit         gl;
        bit         perr;
        bit         serr;
        int         exp_len;
        bit         exp_valid;
        bit         exp_ferr;
        int         exp_deser;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    function automatic logic [5:0] pick_prescale();
        case ($urandom % 3)
            0:       return 6'd8;
            1:       return 6'd16;
            default: return 6'd32;
        endcase
    endfunction

    function automatic logic [6:0] all_outs();
        return {dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid, frame_err};
    endfunction

    task automatic idle_cycles(input int n);
        RX_IN = 1'b1;
        repeat (n) begin
            tick();
            chk("idle_outs", 32'(all_outs()), 0);
            chk("idle_edge", 32'(edge_cnt), 0);
        end
    endtask

    // Serial line value at offset t of a frame: start, LSB-first data, even parity, stop.
    function automatic logic line_bit(input int p, input bit pe, input logic [7:0] d,
                                      input bit gl, input int t);
        int s;
        s = t / p;
        if (gl)               return (t < 3) ? 1'b0 : 1'b1;
        if (s == 0)           return 1'b0;
        if (s <= 8)           return d[s-1];
        if (pe && s == 9)     return ^d;
        return 1'b1;
    endfunction

    // One frame from the cycle before START entry until the DUT leaves the active states.
    task automatic run_frame(input int p, input bit pe, input logic [7:0] d, input bit gl,
                             input bit perr, input bit serr, output int end_seen,
                             output bit v, output bit fe, output int n_deser, output int vcyc);
        int  t;
        int  s;
        int  e;
        int  exp_end;
        int  nseg;
        bit  done;
        nseg     = 10 + int'(pe);
        exp_end  = gl ? p : nseg * p;
        PRESCALE = 6'(p);
        PAR_EN   = pe;
        RX_IN    = 1'b0;
        strt_glitch = 1'b0;
        par_err  = 1'b0;
        stp_err  = 1'b0;
        t        = 0;
        done     = 1'b0;
        n_deser  = 0;
        end_seen = 0;
        v        = 1'b0;
        fe       = 1'b0;
        vcyc     = 0;
        tick();
        while (!done) begin
            s = t / p;
            e = t % p;
            if (t < exp_end) begin
                chk("edge_cnt", 32'(edge_cnt), 32'(e));
                chk("samp_en", 32'(dat_samp_en), 1);
                chk("strobes", 32'({strt_chk_en, deser_en, par_chk_en, stp_chk_en}),
                    32'({s == 0 && e == p-2, s >= 1 && s <= 8 && e == p-2,
                         pe && s == 9 && e == p-2, s == nseg-1 && e == p-2}));
                chk("result_mid", 32'({data_valid, frame_err}), 0);
                if (s >= 1 && s <= 8)  chk("bit_cnt", 32'(bit_cnt), 32'(s - 1));
                else if (s >= 9)       chk("bit_cnt_hold", 32'(bit_cnt), 8);
            end else if (t == exp_end) begin
                chk("end_samp_en", 32'(dat_samp_en), 0);
                chk("end_edge", 32'(edge_cnt), 0);
                chk("end_strobes", 32'({strt_chk_en, deser_en, par_chk_en, stp_chk_en}), 0);
            end
            if (deser_en) n_deser++;
            if (!dat_samp_en || t >= 420) begin
                if (t >= 420) chk("frame_timeout", 32'(t), 32'(exp_end));
                done     = 1'b1;
                end_seen = t;
                v        = data_valid;
                fe       = frame_err;
                vcyc     = cyc;
                strt_glitch = 1'b0;
                par_err  = 1'b0;
                stp_err  = 1'b0;
            end else begin
                RX_IN       = line_bit(p, pe, d, gl, t + 1);
                PRESCALE    = pick_prescale();
                PAR_EN      = 1'($urandom % 2);
                strt_glitch = gl   && s == 0 && e == p-1;
                par_err     = perr && s == 9 && e == p-1;
                stp_err     = serr && s == nseg-1 && e == p-1;
                tick();
                t++;
            end
        end
    endtask

    vec_t vecs[8];

    initial begin
        int  end_seen;
        bit  v;
        bit  fe;
        int  nd;
        int  vc1;
        int  vc2;
        int  p;
        bit  pe;
        bit  gl;
        bit  perr;
        bit  serr;
        int  exp_end;

        vecs[0] = '{8,  1, 8'hA5, 0, 0, 0,  88, 1, 0, 8};
        vecs[1] = '{8,  1, 8'hA5, 0, 1, 0,  88, 0, 1, 8};
        vecs[2] = '{8,  0, 8'hA5, 0, 0, 0,  80, 1, 0, 8};
        vecs[3] = '{8,  1, 8'hA5, 1, 0, 0,   8, 0, 0, 0};
        vecs[4] = '{16, 0, 8'h3C, 0, 0, 0, 160, 1, 0, 8};
        vecs[5] = '{32, 1, 8'hFF, 0, 0, 1, 352, 0, 1, 8};
        vecs[6] = '{16, 1, 8'h00, 0, 1, 1, 176, 0, 1, 8};
        vecs[7] = '{8,  0, 8'h5A, 0, 1, 0,  80, 1, 0, 8};

        RST = 1'b1;
        RX_IN = 1'b1;
        PAR_EN = 1'b0;
        PRESCALE = 6'd8;
        strt_glitch = 1'b0;
        par_err = 1'b0;
        stp_err = 1'b0;
        #3;
        chk("reset_outs", 32'(all_outs()), 0);
        chk("reset_cnts", 32'({edge_cnt, bit_cnt}), 0);
        tick();
        tick();
        RST = 1'b0;
        idle_cycles(3);

        foreach (vecs[i]) begin
            run_frame(vecs[i].p, vecs[i].pe, vecs[i].d, vecs[i].gl, vecs[i].perr,
                      vecs[i].serr, end_seen, v, fe, nd, vc1);
            chk("tbl_len", 32'(end_seen), 32'(vecs[i].exp_len));
            chk("tbl_valid", 32'(v), 32'(vecs[i].exp_valid));
            chk("tbl_ferr", 32'(fe), 32'(vecs[i].exp_ferr));
            chk("tbl_deser", 32'(nd), 32'(vecs[i].exp_deser));
            idle_cycles(2);
        end

        // Glitch, then a real start on the very next cycle.
        run_frame(8, 1, 8'hA5, 1, 0, 0, end_seen, v, fe, nd, vc1);
        chk("glitch_len", 32'(end_seen), 8);
        chk("glitch_pulses", 32'({v, fe}), 0);
        run_frame(8, 1, 8'hA5, 0, 0, 0, end_seen, v, fe, nd, vc1);
        chk("after_glitch_len", 32'(end_seen), 88);
        chk("after_glitch_valid", 32'(v), 1);

        // Back-to-back frames, second start seen during VALID.
        idle_cycles(2);
        run_frame(16, 0, 8'h3C, 0, 0, 0, end_seen, v, fe, nd, vc1);
        chk("b2b_valid1", 32'(v), 1);
        run_frame(16, 0, 8'hFF, 0, 0, 0, end_seen, v, fe, nd, vc2);
        chk("b2b_valid2", 32'(v), 1);
        chk("b2b_gap", 32'(vc2 - vc1), 161);
        idle_cycles(2);

        // Reset asserted mid-DATA with bit_cnt == 4.
        PRESCALE = 6'd8;
        PAR_EN = 1'b1;
        RX_IN = 1'b0;
        tick();
        RX_IN = 1'b1;
        repeat (42) tick();
        chk("pre_reset_bit_cnt", 32'(bit_cnt), 4);
        chk("pre_reset_samp", 32'(dat_samp_en), 1);
        #2;
        RST = 1'b1;
        #1;
        chk("async_reset_outs", 32'(all_outs()), 0);
        chk("async_reset_cnts", 32'({edge_cnt, bit_cnt}), 0);
        tick();
        tick();
        chk("reset_no_pulse", 32'(all_outs()), 0);
        RST = 1'b0;
        idle_cycles(2);
        run_frame(8, 1, 8'hA5, 0, 0, 0, end_seen, v, fe, nd, vc1);
        chk("post_reset_len", 32'(end_seen), 88);
        chk("post_reset_valid", 32'(v), 1);
        idle_cycles(1);

        // Random frames against the timing model.
        for (int i = 0; i < 24; i++) begin
            p       = int'(pick_prescale());
            pe      = 1'($urandom % 2);
            gl      = ($urandom % 6) == 0;
            perr    = ($urandom % 4) == 0;
            serr    = ($urandom % 4) == 0;
            exp_end = gl ? p : (10 + int'(pe)) * p;
            run_frame(p, pe, 8'($urandom), gl, perr, serr, end_seen, v, fe, nd, vc1);
            chk("rnd_len", 32'(end_seen), 32'(exp_end));
            chk("rnd_valid", 32'(v), 32'(!gl && !(serr || (pe && perr))));
            chk("rnd_ferr", 32'(fe), 32'(!gl && (serr || (pe && perr))));
            chk("rnd_deser", 32'(nd), gl ? 0 : 8);
            if ($urandom % 2) idle_cycles(int'($urandom_range(1, 3)));
        end
        idle_cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Receive-side controller for the UART RX path. It detects a start condition on the serial line and drives the per-frame edge/bit counting. It sequences the data sampler, deserializer and the start, parity and stop checkers through one frame, then reports the frame result: a one-cycle `data_valid`, or a one-cycle error pulse. It sits between the RX pin (already synchronised) and the existing RX datapath blocks; the checkers return their error flags to it.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame.
- `PRESCALE_W`, default 6: width of `PRESCALE` and of the edge counter.
- `CLK`  in  1  oversampling clock.
- `RST`  in  1  asynchronous, active-high reset.
- `RX_IN`  in  1  synchronised serial line, idle high.
- `PAR_EN`  in  1  parity bit present in frame; sampled only in IDLE.
- `PRESCALE`  in  PRESCALE_W  oversampling ratio; legal values 8, 16, 32; sampled only in IDLE.
- `strt_glitch`  in  1  start checker error, registered.
- `par_err`  in  1  parity checker error, registered.
- `stp_err`  in  1  stop checker error, registered.
- `dat_samp_en`  out  1  sampler enable.
- `deser_en`  out  1  deserializer shift strobe.
- `strt_chk_en`  out  1  start check strobe.
- `par_chk_en`  out  1  parity check strobe.
- `stp_chk_en`  out  1  stop check strobe.
- `edge_cnt`  out  PRESCALE_W  oversample edge index within the current bit.
- `bit_cnt`  out  4  data bit index.
- `data_valid`  out  1  frame received without error.
- `frame_err`  out  1  frame ended with parity or stop error.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, VALID.
- "Last edge" means `edge_cnt == PRESCALE-1`. "Check edge" means `edge_cnt == PRESCALE-2`.
- Edge counter:
  - Counts 0..PRESCALE-1 in START, DATA, PARITY and STOP; wraps to 0 on the last edge.
  - Held at 0 in IDLE and VALID.
- `bit_cnt`:
  - Cleared on entry to DATA.
  - Increments on each last edge in DATA.
  - Holds in all other states.
- State transitions:
  - IDLE → START when `RX_IN==0`. The first START cycle has `edge_cnt=0`.
  - START, last edge: `strt_glitch` → IDLE (no pulse); otherwise → DATA.
  - DATA, last edge with `bit_cnt==DATA_WIDTH-1`: → PARITY if the latched PAR_EN is 1, else → STOP.
  - PARITY, last edge: → STOP. If `par_err` is 1, set the internal error flag.
  - STOP, last edge: if `stp_err` or the error flag is set → IDLE with `frame_err` pulsed; otherwise → VALID.
  - VALID → START if `RX_IN==0`, else → IDLE.
- The error flag clears on IDLE/VALID → START.
- Output decode, from registered state and counter only (no combinational path from `RX_IN`):
  - `dat_samp_en`: high in START, DATA, PARITY and STOP.
  - `strt_chk_en`: high on the check edge in START.
  - `deser_en`: high on the check edge in DATA.
  - `par_chk_en`: high on the check edge in PARITY.
  - `stp_chk_en`: high on the check edge in STOP.
  - `data_valid`: high in VALID.
- `frame_err`: registered one-cycle pulse, coincident with the cycle after the STOP last edge.
- `PAR_EN` and `PRESCALE` are latched on the IDLE → START or VALID → START transition. Changes mid-frame have no effect.

## Timing
- Reset, asynchronous:
  - State IDLE; `edge_cnt`=0, `bit_cnt`=0, error flag 0.
  - Every output is 0 immediately, mid-frame included.
  - No pulse is emitted for the aborted frame.
- Checker handshake:
  - Strobe on the check edge.
  - The checker's registered error is valid on the last edge and is consumed there.
- Latency from START entry (cycle 0) to `data_valid`: (2 + DATA_WIDTH + PAR_EN) × PRESCALE cycles.
  - PRESCALE=8, DATA_WIDTH=8, parity on: 88.
  - PRESCALE=8, DATA_WIDTH=8, parity off: 80.
- Back-to-back frames: a start bit seen in the VALID cycle enters START the next cycle with no idle gap.
- A start glitch returns to IDLE on the START last edge. A new falling edge is accepted from the next cycle.

## Structure
- Shared package `uart_pkg`: state encoding enum, legal PRESCALE constants, default DATA_WIDTH.
- One natural sub-module: `edge_bit_counter` (edge and bit counters with enable and clear, driven by the FSM).

## Test plan
- PRESCALE=8, PAR_EN=1, even parity, frame 0xA5, parity bit 0, stop 1 → `data_valid` exactly 88 cycles after START entry; 8 `deser_en` pulses; `frame_err` stays 0.
- Same frame with `par_err` forced high at the PARITY last edge → no `data_valid`; `frame_err` pulses once, the cycle after the STOP last edge.
- 3-cycle low glitch on `RX_IN`, `strt_glitch`=1 → return to IDLE at cycle 8; no data strobes; no pulses.
- PRESCALE=16, PAR_EN=0, two back-to-back frames 0x3C and 0xFF, second start low during VALID → two `data_valid` pulses 161 cycles apart.
- `RST` asserted in DATA with `bit_cnt`=4 → all outputs 0 in the same cycle; next frame received cleanly after release.
- `PAR_EN` toggled mid-frame → frame length follows the value latched at START.
